// File: rtl/arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt_pkg.sv
// Shared constants and helpers for the vector synchroniser/deglitch filter.
package arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt_pkg;

    localparam int FILT_CNT_MAX = 255;
    localparam int STAGES_MIN   = 2;
    localparam int STAGES_MAX   = 4;

    // Stability counter width; never below one bit so a bypassed filter still elaborates.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/arf074b032e1r1w0cbbehsaa4acw_ctech_sync_filt_bit.sv
// One bit: N-stage synchroniser chain followed by an optional stability filter and o flop.
module arf074b032e1r1w0cbbehsaa4acw_ctech_sync_filt_bit
    import arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter logic RST_VAL  = 1'b0,
    parameter int   FILT_CNT = 0
) (
    input  logic clk,
    input  logic rst_b,
    input  logic d,
    output logic o
);

    if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
        $error("STAGES out of range 2..4");
    end
    if (FILT_CNT < 0 || FILT_CNT > FILT_CNT_MAX) begin : g_bad_filt
        $error("FILT_CNT out of range 0..255");
    end

    logic [STAGES:0] chain;
    logic            s;

    assign chain[0] = d;

    // Each stage is its own block so a physical sync cell can be dropped in per stage.
    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic stage_q;
        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) stage_q <= RST_VAL;
            else        stage_q <= chain[i];
        end
        assign chain[i+1] = stage_q;
    end

    assign s = chain[STAGES];

    if (FILT_CNT == 0) begin : g_nofilt
        assign o = s;
    end else begin : g_filt
        localparam int            CW     = cnt_width(FILT_CNT);
        localparam logic [CW-1:0] CNT_TC = CW'(FILT_CNT - 1);

        logic [CW-1:0] cnt_q, cnt_d;
        logic          o_q, o_d;

        // Counter only advances while s disagrees with o, so it cannot pass CNT_TC.
        always_comb begin
            cnt_d = '0;
            o_d   = o_q;
            if (s != o_q) begin
                if (cnt_q == CNT_TC) o_d = s;
                else                 cnt_d = cnt_q + CW'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b) begin
                cnt_q <= '0;
                o_q   <= RST_VAL;
            end else begin
                cnt_q <= cnt_d;
                o_q   <= o_d;
            end
        end

        assign o = o_q;
    end

endmodule

// File: rtl/arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt.sv
// WIDTH independent synchronised/deglitched bits with per-bit rise/fall strobes.
module arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt
    import arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt_pkg::*;
#(
    parameter int               WIDTH    = 1,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] RST_VAL  = '0,
    parameter int               FILT_CNT = 0
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] o,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic             o_chg
);

    logic [WIDTH-1:0] o_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        arf074b032e1r1w0cbbehsaa4acw_ctech_sync_filt_bit #(
            .STAGES   (STAGES),
            .RST_VAL  (RST_VAL[i]),
            .FILT_CNT (FILT_CNT)
        ) u_bit (
            .clk   (clk),
            .rst_b (rst_b),
            .d     (d[i]),
            .o     (o[i])
        );
    end

    // o_q resets alongside o, so a reset-forced change never looks like an edge.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) o_q <= RST_VAL;
        else        o_q <= o;
    end

    assign o_rise = o & ~o_q;
    assign o_fall = ~o & o_q;
    assign o_chg  = |(o_rise | o_fall);

endmodule

// File: tb/tb_arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt.sv
// Randomised bench: two configurations checked against a window-based model of sync + filter.
module tb_arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt;

    localparam int MAXE = 4000;

    localparam int         WA = 8, SA = 3, NA = 4;
    localparam logic [7:0] RA = 8'hA5;
    localparam int         WB = 4, SB = 2, NB = 0;
    localparam logic [3:0] RB = 4'h0;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic [7:0] dA = RA;
    logic [3:0] dB = RB;
    logic [7:0] oA, riseA, fallA;
    logic [3:0] oB, riseB, fallB;
    logic       chgA, chgB;

    always #5 clk = ~clk;

    arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt #(
        .WIDTH(WA), .STAGES(SA), .RST_VAL(RA), .FILT_CNT(NA)
    ) u_dut_a (
        .clk(clk), .rst_b(rst_b), .d(dA),
        .o(oA), .o_rise(riseA), .o_fall(fallA), .o_chg(chgA)
    );

    arf074b032e1r1w0cbbehsaa4acw_ctech_sync_vec_filt #(
        .WIDTH(WB), .STAGES(SB), .RST_VAL(RB), .FILT_CNT(NB)
    ) u_dut_b (
        .clk(clk), .rst_b(rst_b), .d(dB),
        .o(oB), .o_rise(riseB), .o_fall(fallB), .o_chg(chgB)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    int         stg [2] = '{SA, SB};
    int         nf  [2] = '{NA, NB};
    int         wd  [2] = '{WA, WB};
    logic [7:0] rv  [2] = '{RA, {4'h0, RB}};
    logic [7:0] dsamp [2][0:MAXE];
    logic [7:0] omod  [2][0:MAXE];
    int         last_upd [2][8];
    int         e = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %h expected %h", tag, e, got, exp);
        end
    endtask

    // Synchronised value after edge k: d as sampled STAGES-1 edges earlier, reset value before that.
    function automatic logic [7:0] s_at(input int u, input int k);
        int idx;
        idx = k - stg[u] + 1;
        if (idx < 1) return rv[u];
        return dsamp[u][idx];
    endfunction

    // o flips at edge e when the last nf synchronised samples all disagree with o and
    // at least nf edges have passed since that bit last changed.
    task automatic model_step(input int u);
        logic [7:0] onew, sv;
        logic       ob;
        bit         ok;
        onew = omod[u][e-1];
        if (nf[u] == 0) begin
            onew = s_at(u, e);
        end else begin
            for (int b = 0; b < wd[u]; b++) begin
                ob = omod[u][e-1][b];
                ok = (e - last_upd[u][b]) >= nf[u];
                for (int j = 1; j <= nf[u]; j++) begin
                    sv = s_at(u, e - j);
                    if (sv[b] == ob) ok = 0;
                end
                if (ok) begin
                    onew[b] = ~ob;
                    last_upd[u][b] = e;
                end
            end
        end
        omod[u][e] = onew;
    endtask

    task automatic check_outputs();
        logic [7:0] er, ef;
        er = omod[0][e] & ~omod[0][e-1];
        ef = ~omod[0][e] & omod[0][e-1];
        check_eq("A_o",    {24'h0, oA},    {24'h0, omod[0][e]});
        check_eq("A_rise", {24'h0, riseA}, {24'h0, er});
        check_eq("A_fall", {24'h0, fallA}, {24'h0, ef});
        check_eq("A_chg",  {31'h0, chgA},  {31'h0, |(er | ef)});
        check_eq("A_excl", {24'h0, riseA & fallA}, 32'h0);
        er = omod[1][e] & ~omod[1][e-1] & 8'h0F;
        ef = ~omod[1][e] & omod[1][e-1] & 8'h0F;
        check_eq("B_o",    {28'h0, oB},    {24'h0, omod[1][e]});
        check_eq("B_rise", {28'h0, riseB}, {24'h0, er});
        check_eq("B_fall", {28'h0, fallB}, {24'h0, ef});
        check_eq("B_chg",  {31'h0, chgB},  {31'h0, |(er | ef)});
        check_eq("B_excl", {28'h0, riseB & fallB}, 32'h0);
    endtask

    task automatic check_in_reset(input string tag);
        check_eq({tag, "_A_o"},  {24'h0, oA}, {24'h0, RA});
        check_eq({tag, "_B_o"},  {28'h0, oB}, {28'h0, RB});
        check_eq({tag, "_strb"}, {24'h0, riseA | fallA | {4'h0, riseB | fallB}}, 32'h0);
        check_eq({tag, "_chg"},  {30'h0, chgA, chgB}, 32'h0);
    endtask

    // Asynchronous assert away from the edge, release one cycle later just after an edge.
    task automatic do_reset();
        rst_b = 1'b0;
        #1;
        check_in_reset("rst_async");
        @(posedge clk);
        #1;
        check_in_reset("rst_held");
        rst_b = 1'b1;
        e = 0;
        for (int u = 0; u < 2; u++) begin
            omod[u][0] = rv[u];
            for (int b = 0; b < 8; b++) last_upd[u][b] = 0;
        end
    endtask

    task automatic step();
        if (e >= MAXE - 1) do_reset();
        @(posedge clk);
        e++;
        dsamp[0][e] = dA;
        dsamp[1][e] = {4'h0, dB};
        model_step(0);
        model_step(1);
        #1;
        check_outputs();
    endtask

    task automatic run_random(input int cycles, input int max_hold);
        int hold_a, hold_b;
        hold_a = 1;
        hold_b = 1;
        for (int c = 0; c < cycles; c++) begin
            if (--hold_a == 0) begin
                dA     = dA ^ 8'($urandom);
                hold_a = $urandom_range(1, max_hold);
            end
            if (--hold_b == 0) begin
                dB     = dB ^ 4'($urandom);
                hold_b = $urandom_range(1, max_hold);
            end
            step();
        end
    endtask

    initial begin
        #2;
        do_reset();

        // Static patterns: first change and its single strobe.
        dA = 8'h5A;
        dB = 4'b0101;
        repeat (30) step();

        // Short pulses: 3 cycles must be swallowed, 4 cycles must pass through.
        dA = 8'h5B;
        repeat (3) step();
        dA = 8'h5A;
        repeat (12) step();
        dA = 8'h5B;
        repeat (4) step();
        dA = 8'h5A;
        repeat (15) step();

        // Reset while the filter is part-way through counting.
        dA = ~RA;
        dB = 4'b1010;
        repeat (SA + 2) step();
        do_reset();
        repeat (20) step();

        run_random(800, 20);
        run_random(500, 5);
        do_reset();
        run_random(600, 20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
